// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MDU op codes, FSM states and op-class helpers
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit with fixed-latency HI/LO commit
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mdu_state_e       r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_res_hi;
    logic [31:0]      r_res_lo;
    logic             r_res_wr;

    mdu_state_e       w_state_next;
    logic             w_busy_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_hi_next;
    logic [31:0]      w_lo_next;
    logic             w_latch;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic [63:0]      w_mul_a;
    logic [63:0]      w_mul_b;
    logic [63:0]      w_prod;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic [31:0]      w_b_safe;
    logic [31:0]      w_q_mag;
    logic [31:0]      w_r_mag;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_res_wr;

    assign w_is_mul = is_mul_op(E_MDUOp);
    assign w_is_div = is_div_op(E_MDUOp);
    assign w_signed = (E_MDUOp == MDU_MULT) || (E_MDUOp == MDU_DIV);

    assign E_Start = (w_is_mul || w_is_div) && !r_busy;
    assign E_Busy  = r_busy;
    assign E_HI    = r_hi;
    assign E_LO    = r_lo;

    // Division runs on magnitudes so the most-negative / -1 case needs no special path.
    always_comb begin
        w_mul_a  = {{32{w_signed & E_A[31]}}, E_A};
        w_mul_b  = {{32{w_signed & E_B[31]}}, E_B};
        w_prod   = w_mul_a * w_mul_b;
        w_a_neg  = w_signed & E_A[31];
        w_b_neg  = w_signed & E_B[31];
        w_a_mag  = w_a_neg ? (32'd0 - E_A) : E_A;
        w_b_mag  = w_b_neg ? (32'd0 - E_B) : E_B;
        w_b_safe = (E_B == 32'd0) ? 32'd1 : w_b_mag;
        w_q_mag  = w_a_mag / w_b_safe;
        w_r_mag  = w_a_mag % w_b_safe;
        w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        w_res_hi = w_is_mul ? w_prod[63:32] : w_rem;
        w_res_lo = w_is_mul ? w_prod[31:0]  : w_quot;
        w_res_wr = w_is_mul || (E_B != 32'd0);
    end

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = r_busy;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (E_Start) begin
                    w_state_next = ST_RUN;
                    w_busy_next  = 1'b1;
                    w_cnt_next   = w_is_mul ? MULT_LOAD : DIV_LOAD;
                    w_latch      = 1'b1;
                end else if (E_MDUOp == MDU_MTHI) begin
                    w_hi_next = E_A;
                end else if (E_MDUOp == MDU_MTLO) begin
                    w_lo_next = E_A;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                    if (r_res_wr) begin
                        w_hi_next = r_res_hi;
                        w_lo_next = r_res_lo;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            if (w_latch) begin
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_res_wr <= w_res_wr;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed plus randomized self-checking bench for e_mdu
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  E_MDUOp = 4'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDUOp (E_MDUOp),
        .E_A     (E_A),
        .E_B     (E_B),
        .E_Start (E_Start),
        .E_Busy  (E_Busy),
        .E_HI    (E_HI),
        .E_LO    (E_LO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted op, from plain 64-bit arithmetic.
    task automatic ref_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MDU_MULT:  begin sp = sa * sb; mdl_hi = sp[63:32]; mdl_lo = sp[31:0]; end
            MDU_MULTU: begin up = ua * ub; mdl_hi = up[63:32]; mdl_lo = up[31:0]; end
            MDU_DIV:   if (b != 0) begin sq = sa / sb; sr = sa % sb; mdl_lo = sq[31:0]; mdl_hi = sr[31:0]; end
            MDU_DIVU:  if (b != 0) begin up = ua / ub; mdl_lo = up[31:0]; up = ua % ub; mdl_hi = up[31:0]; end
            MDU_MTHI:  mdl_hi = a;
            MDU_MTLO:  mdl_lo = a;
            default:   ;
        endcase
    endtask

    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [31:0] h0, l0;
        n  = (op == MDU_MULT || op == MDU_MULTU) ? MC : DC;
        h0 = mdl_hi;
        l0 = mdl_lo;
        @(negedge clk);
        E_MDUOp = op; E_A = a; E_B = b;
        #1;
        chk("start_idle", 32'(E_Start), 32'd1);
        @(posedge clk); #1;
        chk("busy_first", 32'(E_Busy), 32'd1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (i == 1) begin
                E_MDUOp = MDU_MTLO; E_A = 32'hAAAA5555;
            end else begin
                E_MDUOp = 4'($urandom_range(0, 15)); E_A = $urandom;
            end
            E_B = $urandom;
            #1;
            chk("start_busy", 32'(E_Start), 32'd0);
            @(posedge clk); #1;
            chk("busy_hold", 32'(E_Busy), 32'd1);
            chk("hi_hold", E_HI, h0);
            chk("lo_hold", E_LO, l0);
        end
        @(posedge clk); #1;
        ref_apply(op, a, b);
        chk("busy_fall", 32'(E_Busy), 32'd0);
        chk("hi_commit", E_HI, mdl_hi);
        chk("lo_commit", E_LO, mdl_lo);
    endtask

    task automatic run_mt(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        E_MDUOp = op; E_A = a; E_B = $urandom;
        #1;
        chk("start_mt", 32'(E_Start), 32'd0);
        @(posedge clk); #1;
        ref_apply(op, a, 32'd0);
        chk("busy_mt", 32'(E_Busy), 32'd0);
        chk("hi_mt", E_HI, mdl_hi);
        chk("lo_mt", E_LO, mdl_lo);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(E_Busy), 32'd0);
        chk("rst_hi", E_HI, 32'd0);
        chk("rst_lo", E_LO, 32'd0);
        chk("rst_start", 32'(E_Start), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_mt(MDU_MTHI, 32'h12345678);
        chk("mthi_const", E_HI, 32'h12345678);

        run_long(MDU_MULT, 32'hFFFFFFFF, 32'h00000002);
        chk("mult_hi_const", E_HI, 32'hFFFFFFFF);
        chk("mult_lo_const", E_LO, 32'hFFFFFFFE);

        // Issued in the cycle right after busy falls
        run_long(MDU_MULTU, 32'hFFFFFFFF, 32'h00000002);
        chk("multu_hi_const", E_HI, 32'h00000001);
        chk("multu_lo_const", E_LO, 32'hFFFFFFFE);

        run_long(MDU_DIV, 32'hFFFFFFF9, 32'h00000002);
        chk("div_lo_const", E_LO, 32'hFFFFFFFD);
        chk("div_hi_const", E_HI, 32'hFFFFFFFF);

        run_long(MDU_DIVU, 32'd7, 32'd0);
        chk("divu0_hi_const", E_HI, 32'hFFFFFFFF);
        chk("divu0_lo_const", E_LO, 32'hFFFFFFFD);

        run_long(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo_const", E_LO, 32'h80000000);
        chk("div_ovf_hi_const", E_HI, 32'h00000000);

        // Reset during busy cycle 4 of a div
        @(negedge clk);
        E_MDUOp = MDU_DIV; E_A = 32'd1000; E_B = 32'd7;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        E_MDUOp = MDU_NONE;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy", 32'(E_Busy), 32'd0);
        chk("rst_mid_hi", E_HI, 32'd0);
        chk("rst_mid_lo", E_LO, 32'd0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_rst_busy", 32'(E_Busy), 32'd0);
            chk("post_rst_hi", E_HI, 32'd0);
            chk("post_rst_lo", E_LO, 32'd0);
        end

        // Reset pulse that never spans a rising edge has no effect
        run_mt(MDU_MTLO, 32'h0BADF00D);
        @(negedge clk);
        E_MDUOp = MDU_NONE;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("glitch_lo", E_LO, 32'h0BADF00D);
        chk("glitch_busy", 32'(E_Busy), 32'd0);

        // Randomized ops against the reference model
        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(1, 6));
            a  = rnd_val();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val();
            if (op == MDU_MTHI || op == MDU_MTLO)
                run_mt(op, a);
            else
                run_long(op, a, b);
        end

        @(negedge clk);
        E_MDUOp = MDU_NONE;
        @(posedge clk); #1;
        chk("final_hi", E_HI, mdl_hi);
        chk("final_lo", E_LO, mdl_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 SHALL have port E_MDUOp  input  4  operation code from E-stage decode, 0 = none.
REQ-006 SHALL have port E_A  input  32  operand rs (forwarded).
REQ-007 SHALL have port E_B  input  32  operand rt (forwarded).
REQ-008 SHALL have port E_Start  output  1  combinational; high when E_MDUOp is mult/multu/div/divu and busy is low.
REQ-009 SHALL have port E_Busy  output  1  registered; high while a mult/div is in flight.
REQ-010 SHALL have port E_HI  output  32  architectural HI register, piped on to W_HI.
REQ-011 SHALL have port E_LO  output  32  architectural LO register, piped on to W_LO.

Function
REQ-012 SHALL decode ops: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; any other value is no-op.
REQ-013 SHALL accept mult/multu/div/divu only in a cycle where E_Busy=0; accepted at edge T, operands latched at T.
REQ-014 SHALL assert E_Busy from edge T for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), deasserting at edge T+N.
REQ-015 SHALL write E_HI/E_LO at edge T+N, same edge E_Busy falls; E_HI/E_LO hold old values during busy cycles.
REQ-016 SHALL use a down-counter loaded with N-1 at acceptance; states IDLE, RUN; RUN->IDLE when counter reaches 0.
REQ-017 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; divu: unsigned.
REQ-019 div/divu with E_B=0 SHALL still run DIV_CYCLES busy cycles and SHALL leave E_HI/E_LO unchanged.
REQ-020 mthi/mtlo with E_Busy=0 SHALL write E_A to HI/LO at the next edge with no busy cycles.
REQ-021 Any op (including mthi/mtlo) presented while E_Busy=1 SHALL be ignored; no state change, no restart.
REQ-022 Back-to-back: a new mult/div presented in the cycle after E_Busy falls SHALL be accepted normally.
REQ-023 E_Start SHALL be purely combinational from E_MDUOp and E_Busy, so the hazard unit stalls D in the issue cycle.
REQ-024 Result computation may be combinational at latch time; only the commit timing is cycle-exact.

Reset
REQ-025 With reset=0 at a rising edge: E_Busy=0, counter=0, state IDLE, E_HI=0, E_LO=0.
REQ-026 Reset mid-operation SHALL abort the op; no late HI/LO write after reset releases.
REQ-027 reset SHALL have no effect between clock edges.

Structure
REQ-028 MDU op codes (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO) SHALL live in the shared constant.v.
REQ-029 SHALL be a single module with no sub-module; the E-stage decoder drives E_MDUOp.

Verification
REQ-030 mult A=0xFFFFFFFF B=0x00000002 -> 5 busy cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-031 multu A=0xFFFFFFFF B=0x00000002 -> 5 busy cycles, then HI=0x00000001 LO=0xFFFFFFFE.
REQ-032 div A=0xFFFFFFF9 B=0x00000002 -> 10 busy cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu 7/0 -> 10 busy cycles, HI/LO unchanged.
REQ-033 mthi A=0x12345678 idle -> HI=0x12345678 next edge, E_Busy stays 0; mtlo A=0xAAAA5555 during a running mult -> ignored, LO = product.
REQ-034 reset=0 at busy cycle 4 of div -> next edge E_Busy=0 HI=LO=0, and no HI/LO change for 10 following cycles.
REQ-035 mult issued the cycle E_Busy falls -> E_Start=1, accepted, E_Busy high again next edge.
